dff_sr_sync: RTL and testbench

//   Storage cell: positive-edge D flip-flop with synchronous, active-low reset
//   and true plus complement outputs.

---
 rtl/dff_sr_sync.sv | 16 +
 tb/tb_dff_sr_sync.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dff_sr_sync.sv
// dff_sr_sync: rising-edge D flip-flop bank with synchronous active-low reset and complement outputs
module dff_sr_sync #(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);
    // capture d each rising edge; low rst overrides d with RST_VAL
    always_ff @(posedge clk)
        q <= rst ? d : RST_VAL;
    assign qbar = ~q;
endmodule

// File: tb/tb_dff_sr_sync.sv
// tb_dff_sr_sync: scoreboard bench for the 1-bit default and the 4-bit RST_VAL=4'hA flip-flop
module tb_dff_sr_sync;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d1 = 1'b0;
    logic q1, qb1;
    logic [3:0] d4 = 4'h0;
    logic [3:0] q4, qb4;
    logic exp1_q[$];
    logic [3:0] exp4_q[$];
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dff_sr_sync u1 (.d(d1), .clk(clk), .rst(rst), .q(q1), .qbar(qb1));
    dff_sr_sync #(.WIDTH(4), .RST_VAL(4'hA)) u4 (.d(d4), .clk(clk), .rst(rst), .q(q4), .qbar(qb4));

    // drive at the falling edge, predict the value the next rising edge must load
    task automatic drive(input logic r, input logic v1, input logic [3:0] v4);
        @(negedge clk);
        rst = r;
        d1 = v1;
        d4 = v4;
        exp1_q.push_back(r ? v1 : 1'b0);
        exp4_q.push_back(r ? v4 : 4'hA);
    endtask

    task automatic test_reset;
        logic e1;
        logic [3:0] e4;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i % 2 == 0), 4'hF ^ 4'(i));
            @(posedge clk); #1;
            e1 = exp1_q.pop_front();
            e4 = exp4_q.pop_front();
            total++; if (q1 !== e1) $display("FAIL reset q1[%0d] got=%b exp=%b", i, q1, e1); else passed++;
            total++; if (qb1 !== ~e1) $display("FAIL reset qbar1[%0d] got=%b exp=%b", i, qb1, ~e1); else passed++;
            total++; if (q4 !== e4) $display("FAIL reset q4[%0d] got=%h exp=%h", i, q4, e4); else passed++;
            total++; if (qb4 !== ~e4) $display("FAIL reset qbar4[%0d] got=%h exp=%h", i, qb4, ~e4); else passed++;
        end
    endtask

    task automatic test_capture;
        logic [4:0] pat1 = 5'b10101;
        logic [3:0] pat4[5] = '{4'h6, 4'h9, 4'hF, 4'h0, 4'h3};
        logic e1;
        logic [3:0] e4;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pat1[4-i], pat4[i]);
            @(posedge clk); #1;
            e1 = exp1_q.pop_front();
            e4 = exp4_q.pop_front();
            total++; if (q1 !== e1) $display("FAIL capture q1[%0d] got=%b exp=%b", i, q1, e1); else passed++;
            total++; if (qb1 !== ~e1) $display("FAIL capture qbar1[%0d] got=%b exp=%b", i, qb1, ~e1); else passed++;
            total++; if (q4 !== e4) $display("FAIL capture q4[%0d] got=%h exp=%h", i, q4, e4); else passed++;
            total++; if (qb4 !== ~e4) $display("FAIL capture qbar4[%0d] got=%h exp=%h", i, qb4, ~e4); else passed++;
        end
    endtask

    task automatic test_hold;
        #1 d1 = 1'b0; d4 = 4'h8;
        #1 d1 = 1'b1; d4 = 4'h1;
        #1 d1 = 1'b0; d4 = 4'hE;
        @(negedge clk); #1;
        total++; if (q1 !== 1'b1) $display("FAIL hold q1 got=%b exp=1", q1); else passed++;
        total++; if (qb1 !== 1'b0) $display("FAIL hold qbar1 got=%b exp=0", qb1); else passed++;
        total++; if (q4 !== 4'h3) $display("FAIL hold q4 got=%h exp=3", q4); else passed++;
        total++; if (qb4 !== 4'hC) $display("FAIL hold qbar4 got=%h exp=c", qb4); else passed++;
    endtask

    task automatic test_reset_mid;
        logic e1;
        logic [3:0] e4;
        for (int i = 0; i < 2; i++) begin
            drive(i == 1, 1'b1, 4'h7);
            @(posedge clk); #1;
            e1 = exp1_q.pop_front();
            e4 = exp4_q.pop_front();
            total++; if (q1 !== e1) $display("FAIL reset_mid q1[%0d] got=%b exp=%b", i, q1, e1); else passed++;
            total++; if (q4 !== e4) $display("FAIL reset_mid q4[%0d] got=%h exp=%h", i, q4, e4); else passed++;
        end
    endtask

    task automatic test_sync_reset;
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (q1 !== 1'b1) $display("FAIL sync_reset q1 got=%b exp=1", q1); else passed++;
        total++; if (q4 !== 4'h7) $display("FAIL sync_reset q4 got=%h exp=7", q4); else passed++;
        exp1_q.push_back(d1);
        exp4_q.push_back(d4);
        @(posedge clk); #1;
        total++; if (q1 !== exp1_q.pop_front()) $display("FAIL sync_reset_edge q1 got=%b exp=1", q1); else passed++;
        total++; if (q4 !== exp4_q.pop_front()) $display("FAIL sync_reset_edge q4 got=%h exp=7", q4); else passed++;
    endtask

    task automatic test_back_to_back;
        logic e1;
        logic [3:0] e4;
        for (int i = 0; i < 40; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom));
            @(posedge clk); #1;
            e1 = exp1_q.pop_front();
            e4 = exp4_q.pop_front();
            total++; if (q1 !== e1 || qb1 !== ~e1) $display("FAIL b2b bit[%0d] q=%b qbar=%b exp_q=%b", i, q1, qb1, e1); else passed++;
            total++; if (q4 !== e4 || qb4 !== ~e4) $display("FAIL b2b vec[%0d] q=%h qbar=%h exp_q=%h", i, q4, qb4, e4); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_capture;
        test_hold;
        test_reset_mid;
        test_sync_reset;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
